// File: rtl/network_receive_endpoint.sv
// Two-flit packet receiver: header/payload reassembly into a DEPTH-entry message FIFO.
// Optional destination filtering with drop counting is enabled by XCTCMSG_DEST_CHECK_EN.
module network_receive_endpoint #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] local_address,
    input  logic        noc_in_valid,
    output logic        noc_in_ready,
    input  logic [63:0] noc_in_data,
    output logic        endpoint_mailbox_valid,
    input  logic        mailbox_endpoint_ready,
    output logic [15:0] endpoint_mailbox_sender,
    output logic [15:0] endpoint_mailbox_tag,
    output logic [63:0] endpoint_mailbox_value,
    output logic [15:0] drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic {
        HDR,
        PLD
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     hdr_sender_q, hdr_sender_d;
    logic [15:0]     hdr_tag_q, hdr_tag_d;
    logic            hdr_drop_q, hdr_drop_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [95:0]     mem_q [DEPTH];
    logic [95:0]     head;

    logic            full;
    logic            xfer;
    logic            push;
    logic            pop;
    logic            drop_xfer;
    logic            dest_mismatch;

    assign full = (count_q == FULL_COUNT);
    assign xfer = noc_in_valid && noc_in_ready;
    assign pop  = (count_q != '0) && mailbox_endpoint_ready;

    always_comb begin
        state_d      = state_q;
        hdr_sender_d = hdr_sender_q;
        hdr_tag_d    = hdr_tag_q;
        hdr_drop_d   = hdr_drop_q;
        noc_in_ready = 1'b1;
        push         = 1'b0;
        drop_xfer    = 1'b0;
        case (state_q)
            HDR: begin
                if (xfer) begin
                    hdr_sender_d = noc_in_data[31:16];
                    hdr_tag_d    = noc_in_data[15:0];
                    hdr_drop_d   = dest_mismatch;
                    state_d      = PLD;
                end
            end
            PLD: begin
                // Readiness uses registered occupancy only, so a same-cycle pop never unblocks.
                noc_in_ready = !full || hdr_drop_q;
                if (xfer) begin
                    push      = !hdr_drop_q;
                    drop_xfer = hdr_drop_q;
                    state_d   = HDR;
                end
            end
            default: state_d = HDR;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HDR;
            hdr_sender_q <= '0;
            hdr_tag_q    <= '0;
            hdr_drop_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            hdr_sender_q <= hdr_sender_d;
            hdr_tag_q    <= hdr_tag_d;
            hdr_drop_q   <= hdr_drop_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {hdr_sender_q, hdr_tag_q, noc_in_data};
        end
    end

    // Storage is not reset; fields are masked to zero whenever the FIFO is empty.
    assign head                    = mem_q[rd_ptr_q];
    assign endpoint_mailbox_valid  = (count_q != '0);
    assign endpoint_mailbox_sender = endpoint_mailbox_valid ? head[95:80] : '0;
    assign endpoint_mailbox_tag    = endpoint_mailbox_valid ? head[79:64] : '0;
    assign endpoint_mailbox_value  = endpoint_mailbox_valid ? head[63:0]  : '0;

`ifdef XCTCMSG_DEST_CHECK_EN
    logic [15:0] drop_count_q, drop_count_d;

    assign dest_mismatch = (noc_in_data[63:32] != local_address);

    always_comb begin
        drop_count_d = drop_count_q;
        if (drop_xfer && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`else
    logic unused_dest;

    assign dest_mismatch = 1'b0;
    assign drop_count    = '0;
    assign unused_dest   = ^{local_address, noc_in_data[63:32], drop_xfer};
`endif

endmodule

// File: tb/tb_network_receive_endpoint.sv
// Directed self-checking bench for network_receive_endpoint (DEPTH 2); expectations
// follow XCTCMSG_DEST_CHECK_EN so the same bench serves both builds.
module tb_network_receive_endpoint;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] local_address;
    logic        noc_in_valid;
    logic        noc_in_ready;
    logic [63:0] noc_in_data;
    logic        endpoint_mailbox_valid;
    logic        mailbox_endpoint_ready;
    logic [15:0] endpoint_mailbox_sender;
    logic [15:0] endpoint_mailbox_tag;
    logic [63:0] endpoint_mailbox_value;
    logic [15:0] drop_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    network_receive_endpoint #(.DEPTH(2)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .local_address          (local_address),
        .noc_in_valid           (noc_in_valid),
        .noc_in_ready           (noc_in_ready),
        .noc_in_data            (noc_in_data),
        .endpoint_mailbox_valid (endpoint_mailbox_valid),
        .mailbox_endpoint_ready (mailbox_endpoint_ready),
        .endpoint_mailbox_sender(endpoint_mailbox_sender),
        .endpoint_mailbox_tag   (endpoint_mailbox_tag),
        .endpoint_mailbox_value (endpoint_mailbox_value),
        .drop_count             (drop_count)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mk_hdr(input logic [31:0] dst, input logic [15:0] snd,
                                           input logic [15:0] tg);
        return {dst, snd, tg};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {valid, sender, tag, value} as one word
    task automatic chk_msg(input string tag, input logic vld, input logic [15:0] snd,
                           input logic [15:0] tg, input logic [63:0] val);
        chk(tag, {endpoint_mailbox_valid, endpoint_mailbox_sender, endpoint_mailbox_tag,
                  endpoint_mailbox_value},
            {vld, snd, tg, val});
    endtask

    // Called at a negedge; returns at the negedge following the transfer edge.
    task automatic send_flit(input string tag, input logic [63:0] d);
        int unsigned n = 0;
        logic done = 1'b0;
        noc_in_valid = 1'b1;
        noc_in_data  = d;
        while (!done && n < 20) begin
            done = noc_in_ready;
            @(negedge clk);
            n++;
        end
        noc_in_valid = 1'b0;
        chk(tag, {127'd0, done}, 128'd1);
    endtask

    task automatic pop_one();
        mailbox_endpoint_ready = 1'b1;
        @(negedge clk);
        mailbox_endpoint_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n                  = 1'b0;
        local_address          = 32'h10;
        noc_in_valid           = 1'b0;
        noc_in_data            = '0;
        mailbox_endpoint_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);

        chk("rst_ready", {127'd0, noc_in_ready}, 128'd1);
        chk_msg("rst_msg", 1'b0, 16'h0, 16'h0, 64'h0);
        chk("rst_drop", {112'd0, drop_count}, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // single packet with mailbox ready held high
        mailbox_endpoint_ready = 1'b1;
        send_flit("t1_hdr", 64'h00000010_0003_00A5);
        send_flit("t1_pld", 64'hDEADBEEF_CAFEF00D);
        chk_msg("t1_msg", 1'b1, 16'h0003, 16'h00A5, 64'hDEADBEEF_CAFEF00D);
        @(negedge clk);
        chk_msg("t1_after_pop", 1'b0, 16'h0, 16'h0, 64'h0);
        mailbox_endpoint_ready = 1'b0;

        // fill to DEPTH and backpressure the third payload
        send_flit("t2_h1", mk_hdr(32'h10, 16'h0101, 16'h0011));
        send_flit("t2_p1", 64'h1111_1111_1111_1111);
        send_flit("t2_h2", mk_hdr(32'h10, 16'h0202, 16'h0022));
        send_flit("t2_p2", 64'h2222_2222_2222_2222);
        send_flit("t2_h3", mk_hdr(32'h10, 16'h0303, 16'h0033));
        chk("t2_stall", {127'd0, noc_in_ready}, 128'd0);
        @(negedge clk);
        @(negedge clk);
        chk("t2_stall_hold", {127'd0, noc_in_ready}, 128'd0);
        chk_msg("t2_head1", 1'b1, 16'h0101, 16'h0011, 64'h1111_1111_1111_1111);
        noc_in_valid           = 1'b1;
        noc_in_data            = 64'h3333_3333_3333_3333;
        mailbox_endpoint_ready = 1'b1;
        @(negedge clk);
        mailbox_endpoint_ready = 1'b0;
        chk("t2_unstall", {127'd0, noc_in_ready}, 128'd1);
        chk_msg("t2_head2", 1'b1, 16'h0202, 16'h0022, 64'h2222_2222_2222_2222);
        @(negedge clk);
        noc_in_valid = 1'b0;
        chk("t2_full_again", {127'd0, noc_in_ready}, 128'd1);
        pop_one();
        chk_msg("t2_head3", 1'b1, 16'h0303, 16'h0033, 64'h3333_3333_3333_3333);
        pop_one();
        chk_msg("t2_empty", 1'b0, 16'h0, 16'h0, 64'h0);

        // simultaneous push and pop at occupancy 1
        send_flit("t3_ha", mk_hdr(32'h10, 16'h0A0A, 16'h000A));
        send_flit("t3_pa", 64'hAAAA_AAAA_AAAA_AAAA);
        send_flit("t3_hb", mk_hdr(32'h10, 16'h0B0B, 16'h000B));
        noc_in_valid           = 1'b1;
        noc_in_data            = 64'hBBBB_BBBB_BBBB_BBBB;
        mailbox_endpoint_ready = 1'b1;
        @(negedge clk);
        noc_in_valid           = 1'b0;
        mailbox_endpoint_ready = 1'b0;
        chk_msg("t3_head_b", 1'b1, 16'h0B0B, 16'h000B, 64'hBBBB_BBBB_BBBB_BBBB);
        @(negedge clk);
        chk_msg("t3_hold_b", 1'b1, 16'h0B0B, 16'h000B, 64'hBBBB_BBBB_BBBB_BBBB);
        pop_one();
        chk_msg("t3_occ_one", 1'b0, 16'h0, 16'h0, 64'h0);

        // destination mismatch
        send_flit("t4_hdr", mk_hdr(32'h11, 16'h0404, 16'h0044));
        send_flit("t4_pld", 64'h4444_4444_4444_4444);
`ifdef XCTCMSG_DEST_CHECK_EN
        chk_msg("t4_dropped", 1'b0, 16'h0, 16'h0, 64'h0);
        chk("t4_drop_cnt", {112'd0, drop_count}, 128'd1);
`else
        chk_msg("t4_enqueued", 1'b1, 16'h0404, 16'h0044, 64'h4444_4444_4444_4444);
        chk("t4_drop_cnt", {112'd0, drop_count}, 128'd0);
        pop_one();
`endif

        // mid-packet gap
        send_flit("t5_hdr", mk_hdr(32'h10, 16'h0505, 16'h0055));
        repeat (3) @(negedge clk);
        chk("t5_gap_ready", {126'd0, noc_in_ready, endpoint_mailbox_valid}, 128'd2);
        send_flit("t5_pld", 64'h5555_5555_5555_5555);
        chk_msg("t5_msg", 1'b1, 16'h0505, 16'h0055, 64'h5555_5555_5555_5555);
        pop_one();

        // reset mid-packet discards the pending header
        send_flit("t5_hdr_lost", mk_hdr(32'h10, 16'h0606, 16'h0066));
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_out", {126'd0, noc_in_ready, endpoint_mailbox_valid}, 128'd2);
        rst_n = 1'b1;
        @(negedge clk);
        send_flit("t5_hdr_new", mk_hdr(32'h10, 16'h0707, 16'h0077));
        send_flit("t5_pld_new", 64'h7777_7777_7777_7777);
        chk_msg("t5_new_msg", 1'b1, 16'h0707, 16'h0077, 64'h7777_7777_7777_7777);
        pop_one();
        chk_msg("t5_only_new", 1'b0, 16'h0, 16'h0, 64'h0);

        // drop_count saturation
`ifdef XCTCMSG_DEST_CHECK_EN
        dut.drop_count_q = 16'hFFFE;
`else
        mailbox_endpoint_ready = 1'b1;
`endif
        for (int i = 0; i < 3; i++) begin
            send_flit("t6_hdr", mk_hdr(32'h11, 16'h0808, 16'h0088));
            send_flit("t6_pld", 64'h8888_8888_8888_8888);
        end
        @(negedge clk);
        mailbox_endpoint_ready = 1'b0;
`ifdef XCTCMSG_DEST_CHECK_EN
        chk("t6_saturate", {112'd0, drop_count}, 128'h0FFFF);
`else
        chk("t6_no_drop", {112'd0, drop_count}, 128'd0);
`endif
        chk_msg("t6_empty", 1'b0, 16'h0, 16'h0, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
